vlsu_req_fragmenter: RTL and testbench

//  Converts one accepted vector memory command (incr/strided/row-2D/column-2D) into a stream of bus burst

---
 rtl/vlsu_req_fragmenter_pkg.sv | 42 ++++
 rtl/vlsu_burst_calc.sv | 33 +++
 rtl/vlsu_req_fragmenter.sv | 198 +++++++++++++++++++
 tb/tb_vlsu_req_fragmenter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_req_fragmenter_pkg.sv
// Shared types, widths and mode decode for the VLSU request fragmenter.
package vlsu_req_fragmenter_pkg;

  localparam int unsigned FRAG_ADDR_W = 64;
  localparam int unsigned FRAG_LEN_W  = 16;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} frag_state_e;

  typedef struct packed {
    logic [FRAG_ADDR_W-1:0] addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [FRAG_LEN_W+2:0]  bytes;
    logic                   last;
  } frag_req_t;

  function automatic int unsigned max_burst_bytes(input int unsigned bus_bytes,
                                                  input int unsigned max_beats);
    return bus_bytes * max_beats;
  endfunction

  function automatic logic is_incr(input logic [3:0] mode);
    return mode == 4'b0001;
  endfunction

  function automatic logic is_strd(input logic [3:0] mode);
    return mode == 4'b0010;
  endfunction

  function automatic logic is_row2d(input logic [3:0] mode);
    return mode == 4'b0100;
  endfunction

  function automatic logic is_cln2d(input logic [3:0] mode);
    return mode == 4'b1000;
  endfunction

  function automatic logic is_2d(input logic [3:0] mode);
    return is_row2d(mode) || is_cln2d(mode);
  endfunction

endpackage

// File: rtl/vlsu_burst_calc.sv
// Sizes one burst: clips the segment remainder at the max-burst boundary and
// derives the beat count from the bus-lane offset of the start address.
module vlsu_burst_calc
  import vlsu_req_fragmenter_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 16,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned BYTES_W   = 19,
  localparam int unsigned MBB_LG   = $clog2(max_burst_bytes(BUS_BYTES, MAX_BEATS))
) (
  input  logic [MBB_LG-1:0]  addr_lo_i,
  input  logic [BYTES_W-1:0] seg_rem_i,
  output logic [BYTES_W-1:0] bytes_o,
  output logic [7:0]         len_o
);

  localparam int unsigned BUS_LG = $clog2(BUS_BYTES);
  localparam int unsigned SPAN_W = MBB_LG + 1;

  logic [SPAN_W-1:0] room;
  logic [SPAN_W-1:0] span;
  logic [SPAN_W-1:0] beats;

  // Lane offset plus clipped bytes never exceeds the max burst size, so SPAN_W suffices.
  always_comb begin
    room    = SPAN_W'(max_burst_bytes(BUS_BYTES, MAX_BEATS)) - SPAN_W'(addr_lo_i);
    bytes_o = (seg_rem_i < BYTES_W'(room)) ? seg_rem_i : BYTES_W'(room);
    span    = SPAN_W'(addr_lo_i[BUS_LG-1:0]) + SPAN_W'(bytes_o) + SPAN_W'(BUS_BYTES - 1);
    beats   = span >> BUS_LG;
    len_o   = 8'(beats - SPAN_W'(1));
  end

endmodule

// File: rtl/vlsu_req_fragmenter.sv
// Turns one vector memory command into a stream of bus burst requests, one
// per output handshake; bursts never straddle a max-burst-size boundary.
module vlsu_req_fragmenter
  import vlsu_req_fragmenter_pkg::*;
#(
  parameter int unsigned ADDR_W    = FRAG_ADDR_W,
  parameter int unsigned BUS_BYTES = 16,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned LEN_W     = FRAG_LEN_W,
  parameter int unsigned ROW_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_mode_i,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W-1:0] cmd_stride_i,
  input  logic [1:0]        cmd_eew_i,
  input  logic [LEN_W-1:0]  cmd_vl_i,
  input  logic [ROW_W-1:0]  cmd_rows_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [7:0]        req_len_o,
  output logic [2:0]        req_size_o,
  output logic [LEN_W+2:0]  req_bytes_o,
  output logic              req_last_o
);

  localparam int unsigned BYTES_W = LEN_W + 3;
  localparam int unsigned CNT_W   = LEN_W + ROW_W;
  localparam int unsigned BUS_LG  = $clog2(BUS_BYTES);
  localparam int unsigned MBB_LG  = $clog2(max_burst_bytes(BUS_BYTES, MAX_BEATS));

  frag_state_e        state_q, state_d;
  frag_req_t          req_q, req_d;
  logic               req_valid_q, req_valid_d;
  logic [3:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [ROW_W-1:0]   rows_q, rows_d;
  logic [ROW_W-1:0]   row_idx_q, row_idx_d;
  logic [CNT_W-1:0]   seg_cnt_q, seg_cnt_d;
  logic [BYTES_W-1:0] seg_len_q, seg_len_d;
  logic [BYTES_W-1:0] seg_rem_q, seg_rem_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]  seg_addr_q, seg_addr_d;
  logic [ADDR_W-1:0]  col_addr_q, col_addr_d;

  logic               cmd_hs, req_hs, cmd_zero, cmd_legal;
  logic               new_seg, last_row, col_step;
  logic [BYTES_W-1:0] cmd_seg_len, calc_rem, calc_bytes;
  logic [CNT_W-1:0]   cmd_seg_cnt, cnt_after;
  logic [ADDR_W-1:0]  next_seg_addr, calc_addr;
  logic [7:0]         calc_len;
  logic [2:0]         cmd_size;

  assign cmd_ready_o = (state_q == IDLE);
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign req_hs      = req_valid_q && req_ready_i;
  assign cmd_legal   = is_incr(cmd_mode_i) || is_strd(cmd_mode_i) ||
                       is_row2d(cmd_mode_i) || is_cln2d(cmd_mode_i);
  assign cmd_zero    = !cmd_legal || (cmd_vl_i == '0) ||
                       (is_2d(cmd_mode_i) && (cmd_rows_i == '0));

  always_comb begin
    cmd_seg_len = BYTES_W'(cmd_vl_i) << cmd_eew_i;
    cmd_seg_cnt = CNT_W'(1);
    cmd_size    = 3'(BUS_LG);
    if (is_strd(cmd_mode_i) || is_cln2d(cmd_mode_i)) begin
      cmd_seg_len = BYTES_W'(1) << cmd_eew_i;
      cmd_size    = {1'b0, cmd_eew_i};
    end
    if (is_strd(cmd_mode_i)) begin
      cmd_seg_cnt = CNT_W'(cmd_vl_i);
    end else if (is_row2d(cmd_mode_i)) begin
      cmd_seg_cnt = CNT_W'(cmd_rows_i);
    end else if (is_cln2d(cmd_mode_i)) begin
      cmd_seg_cnt = CNT_W'(cmd_vl_i) * CNT_W'(cmd_rows_i);
    end
  end

  // Column-major walks rows innermost; after the last row the next column starts one element over.
  assign last_row      = (row_idx_q == rows_q - ROW_W'(1));
  assign col_step      = is_cln2d(mode_q) && last_row;
  assign next_seg_addr = col_step ? col_addr_q + ADDR_W'(seg_len_q) : seg_addr_q + stride_q;
  assign new_seg       = (seg_rem_q == '0);
  assign calc_addr     = cmd_hs ? cmd_base_i  : (new_seg ? next_seg_addr : cur_addr_q);
  assign calc_rem      = cmd_hs ? cmd_seg_len : (new_seg ? seg_len_q : seg_rem_q);
  assign cnt_after     = cmd_hs ? cmd_seg_cnt - CNT_W'(1)
                                : (new_seg ? seg_cnt_q - CNT_W'(1) : seg_cnt_q);

  vlsu_burst_calc #(
    .BUS_BYTES (BUS_BYTES),
    .MAX_BEATS (MAX_BEATS),
    .BYTES_W   (BYTES_W)
  ) u_burst_calc (
    .addr_lo_i (calc_addr[MBB_LG-1:0]),
    .seg_rem_i (calc_rem),
    .bytes_o   (calc_bytes),
    .len_o     (calc_len)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    req_valid_d = req_valid_q;
    mode_d      = mode_q;
    stride_d    = stride_q;
    rows_d      = rows_q;
    row_idx_d   = row_idx_q;
    seg_cnt_d   = seg_cnt_q;
    seg_len_d   = seg_len_q;
    seg_rem_d   = seg_rem_q;
    cur_addr_d  = cur_addr_q;
    seg_addr_d  = seg_addr_q;
    col_addr_d  = col_addr_q;

    if (state_q == IDLE) begin
      if (cmd_hs && !cmd_zero) begin
        state_d     = BUSY;
        req_valid_d = 1'b1;
        mode_d      = cmd_mode_i;
        stride_d    = cmd_stride_i;
        rows_d      = cmd_rows_i;
        row_idx_d   = '0;
        seg_len_d   = cmd_seg_len;
        seg_addr_d  = cmd_base_i;
        col_addr_d  = cmd_base_i;
        req_d.size  = cmd_size;
      end
    end else if (req_hs) begin
      if (req_q.last) begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
        req_d       = '0;
      end else if (new_seg) begin
        seg_addr_d = next_seg_addr;
        if (col_step) begin
          col_addr_d = next_seg_addr;
          row_idx_d  = '0;
        end else begin
          row_idx_d  = row_idx_q + ROW_W'(1);
        end
      end
    end

    if ((state_q == IDLE && cmd_hs && !cmd_zero) || (state_q == BUSY && req_hs && !req_q.last)) begin
      req_d.addr  = FRAG_ADDR_W'(calc_addr);
      req_d.len   = calc_len;
      req_d.bytes = (FRAG_LEN_W + 3)'(calc_bytes);
      req_d.last  = (calc_bytes == calc_rem) && (cnt_after == '0);
      cur_addr_d  = calc_addr + ADDR_W'(calc_bytes);
      seg_rem_d   = calc_rem - calc_bytes;
      seg_cnt_d   = cnt_after;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      mode_q      <= '0;
      stride_q    <= '0;
      rows_q      <= '0;
      row_idx_q   <= '0;
      seg_cnt_q   <= '0;
      seg_len_q   <= '0;
      seg_rem_q   <= '0;
      cur_addr_q  <= '0;
      seg_addr_q  <= '0;
      col_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      mode_q      <= mode_d;
      stride_q    <= stride_d;
      rows_q      <= rows_d;
      row_idx_q   <= row_idx_d;
      seg_cnt_q   <= seg_cnt_d;
      seg_len_q   <= seg_len_d;
      seg_rem_q   <= seg_rem_d;
      cur_addr_q  <= cur_addr_d;
      seg_addr_q  <= seg_addr_d;
      col_addr_q  <= col_addr_d;
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_addr_o  = ADDR_W'(req_q.addr);
  assign req_len_o   = req_q.len;
  assign req_size_o  = req_q.size;
  assign req_bytes_o = (LEN_W + 3)'(req_q.bytes);
  assign req_last_o  = req_q.last;

endmodule

// File: tb/tb_vlsu_req_fragmenter.sv
// Directed and random commands checked burst-by-burst against a segment/burst
// list built from the addressing rules with plain arithmetic.
module tb_vlsu_req_fragmenter;

  localparam int BUS = 16;
  localparam int MBB = 256;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [3:0]  cmd_mode_i;
  logic [63:0] cmd_base_i;
  logic [63:0] cmd_stride_i;
  logic [1:0]  cmd_eew_i;
  logic [15:0] cmd_vl_i;
  logic [15:0] cmd_rows_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [63:0] req_addr_o;
  logic [7:0]  req_len_o;
  logic [2:0]  req_size_o;
  logic [18:0] req_bytes_o;
  logic        req_last_o;

  vlsu_req_fragmenter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_mode_i   (cmd_mode_i),
    .cmd_base_i   (cmd_base_i),
    .cmd_stride_i (cmd_stride_i),
    .cmd_eew_i    (cmd_eew_i),
    .cmd_vl_i     (cmd_vl_i),
    .cmd_rows_i   (cmd_rows_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_addr_o   (req_addr_o),
    .req_len_o    (req_len_o),
    .req_size_o   (req_size_o),
    .req_bytes_o  (req_bytes_o),
    .req_last_o   (req_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [18:0] bytes;
    logic        last;
  } exp_t;

  exp_t  exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  string cur_cmd = "reset";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s/%s observed=0x%0h expected=0x%0h", cur_cmd, tag, obs, expv);
  endtask

  // Expand the command into byte segments, then cut each segment into bursts.
  function automatic void build_expected(input logic [3:0] mode, input logic [63:0] base,
                                         input logic [63:0] stride, input int eew,
                                         input int vl, input int rows);
    logic [63:0] seg_a[$];
    int          seg_n[$];
    int          esz;
    logic [2:0]  size;
    exp_t        e;
    esz  = 1 << eew;
    size = (mode == 4'b0010 || mode == 4'b1000) ? 3'(eew) : 3'd4;
    exp_q.delete();
    case (mode)
      4'b0001: if (vl > 0) begin seg_a.push_back(base); seg_n.push_back(vl * esz); end
      4'b0010: for (int i = 0; i < vl; i++) begin
                 seg_a.push_back(base + 64'(i) * stride); seg_n.push_back(esz);
               end
      4'b0100: if (vl > 0) for (int r = 0; r < rows; r++) begin
                 seg_a.push_back(base + 64'(r) * stride); seg_n.push_back(vl * esz);
               end
      4'b1000: for (int c = 0; c < vl; c++) for (int r = 0; r < rows; r++) begin
                 seg_a.push_back(base + 64'(c * esz) + 64'(r) * stride); seg_n.push_back(esz);
               end
      default: ;
    endcase
    foreach (seg_a[s]) begin
      logic [63:0] a;
      int rem, off, b;
      a   = seg_a[s];
      rem = seg_n[s];
      while (rem > 0) begin
        off     = int'(a % 64'(MBB));
        b       = (rem < MBB - off) ? rem : MBB - off;
        e.addr  = a;
        e.len   = 8'((int'(a % 64'(BUS)) + b + BUS - 1) / BUS - 1);
        e.size  = size;
        e.bytes = 19'(b);
        e.last  = 1'b0;
        exp_q.push_back(e);
        a   = a + 64'(b);
        rem = rem - b;
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  // Called at posedge+1 with the DUT idle; hold = cycles of forced ready-low at the start.
  task automatic run_cmd(input string name, input logic [3:0] mode, input logic [63:0] base,
                         input logic [63:0] stride, input int eew, input int vl,
                         input int rows, input int hold);
    int cyc;
    cur_cmd = name;
    build_expected(mode, base, stride, eew, vl, rows);
    chk("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i  = 1'b1;
    cmd_mode_i   = mode;
    cmd_base_i   = base;
    cmd_stride_i = stride;
    cmd_eew_i    = 2'(eew);
    cmd_vl_i     = 16'(vl);
    cmd_rows_i   = 16'(rows);
    req_ready_i  = 1'b0;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    if (exp_q.size() == 0) begin
      chk("zero_no_req", 64'(req_valid_o), 64'd0);
      chk("zero_ready", 64'(cmd_ready_o), 64'd1);
      $display("%s: zero work, no bursts", name);
      return;
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      chk("req_valid", 64'(req_valid_o), 64'd1);
      chk("cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
      chk("req_addr", req_addr_o, exp_q[0].addr);
      chk("req_len", 64'(req_len_o), 64'(exp_q[0].len));
      chk("req_size", 64'(req_size_o), 64'(exp_q[0].size));
      chk("req_bytes", 64'(req_bytes_o), 64'(exp_q[0].bytes));
      chk("req_last", 64'(req_last_o), 64'(exp_q[0].last));
      req_ready_i = (cyc >= hold) && ($urandom_range(0, 3) != 0);
      if (req_ready_i)
        $display("%s: burst addr=0x%0h len=%0d size=%0d bytes=%0d last=%0d",
                 name, req_addr_o, req_len_o, req_size_o, req_bytes_o, req_last_o);
      @(posedge clk_i); #1;
      if (req_ready_i) void'(exp_q.pop_front());
      cyc++;
    end
    req_ready_i = 1'b0;
    chk("drain_in_budget", 64'(exp_q.size()), 64'd0);
    chk("idle_no_valid", 64'(req_valid_o), 64'd0);
    chk("idle_ready", 64'(cmd_ready_o), 64'd1);
  endtask

  initial begin
    int          s, mode_sel, eew, vl, rows;
    logic [3:0]  mode;
    logic [63:0] stride;

    rst_ni       = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_mode_i   = '0;
    cmd_base_i   = '0;
    cmd_stride_i = '0;
    cmd_eew_i    = '0;
    cmd_vl_i     = '0;
    cmd_rows_i   = '0;
    req_ready_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_req_valid", 64'(req_valid_o), 64'd0);
    chk("rst_req_addr", req_addr_o, 64'd0);
    chk("rst_req_len", 64'(req_len_o), 64'd0);
    chk("rst_req_size", 64'(req_size_o), 64'd0);
    chk("rst_req_bytes", 64'(req_bytes_o), 64'd0);
    chk("rst_req_last", 64'(req_last_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_cmd("incr_4k",  4'b0001, 64'h1008, 64'h0,  2, 100, 0, 0);
    run_cmd("strd",     4'b0010, 64'h0,    64'h40, 3, 3,   0, 0);
    run_cmd("row2d",    4'b0100, 64'h2000, 64'h100, 2, 8,  2, 0);
    run_cmd("cln2d",    4'b1000, 64'h0,    64'h80, 2, 2,   2, 0);
    run_cmd("strd_neg", 4'b0010, 64'h8,    64'hFFFF_FFFF_FFFF_FFF0, 3, 2, 0, 3);
    run_cmd("vl_zero",  4'b0001, 64'h100,  64'h0,  0, 0,   0, 0);
    run_cmd("rows_zero", 4'b0100, 64'h100, 64'h40, 1, 4,   0, 0);
    run_cmd("illegal",  4'b0110, 64'h100,  64'h40, 1, 4,   2, 0);
    run_cmd("incr_wrap", 4'b0001, 64'hFFFF_FFFF_FFFF_FFF4, 64'h0, 3, 40, 0, 0);

    // Reset in the middle of a row2D command drops it outright.
    cur_cmd      = "reset_mid";
    cmd_valid_i  = 1'b1;
    cmd_mode_i   = 4'b0100;
    cmd_base_i   = 64'h3000;
    cmd_stride_i = 64'h200;
    cmd_eew_i    = 2'd3;
    cmd_vl_i     = 16'd64;
    cmd_rows_i   = 16'd4;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    chk("busy_valid", 64'(req_valid_o), 64'd1);
    chk("busy_addr", req_addr_o, 64'h3000);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 64'(req_valid_o), 64'd0);
    chk("async_rst_ready", 64'(cmd_ready_o), 64'd1);
    chk("async_rst_addr", req_addr_o, 64'd0);
    chk("async_rst_last", 64'(req_last_o), 64'd0);
    $display("reset_mid: command dropped by reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("post_rst_idle", 64'(req_valid_o), 64'd0);
    run_cmd("after_rst", 4'b1000, 64'h40F8, 64'h10, 3, 3, 3, 0);

    for (int t = 0; t < 30; t++) begin
      mode_sel = $urandom_range(0, 5);
      case (mode_sel)
        0: mode = 4'b0001;
        1: mode = 4'b0010;
        2: mode = 4'b0100;
        3: mode = 4'b1000;
        4: mode = 4'b1000;
        default: mode = 4'($urandom_range(0, 15));
      endcase
      s      = int'($urandom_range(0, 1024)) - 512;
      stride = {{32{s[31]}}, s};
      eew    = $urandom_range(0, 3);
      vl     = (mode == 4'b0001 || mode == 4'b0100) ? $urandom_range(0, 300) : $urandom_range(0, 6);
      rows   = $urandom_range(0, 4);
      run_cmd($sformatf("rand%0d", t), mode, {$urandom, $urandom}, stride, eew, vl, rows,
              $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
